// File: rtl/accumulator_pkg.sv
// accumulator_pkg: default widths and saturation mode constants for the accumulator
package accumulator_pkg;
  localparam int DATA_W_DFLT = 8;
  localparam int SUM_W_DFLT = 16;
  localparam bit WRAP = 1'b0;
  localparam bit SAT = 1'b1;
endpackage

// File: rtl/accumulator_if.sv
// accumulator_if: bundle of accumulator stimulus and result signals
interface accumulator_if
  import accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int SUM_W = SUM_W_DFLT
);
  logic rst;
  logic [DATA_W-1:0] data_in;
  logic [SUM_W-1:0] sum;
  logic overflow;
endinterface

// File: rtl/accumulator_add.sv
// accumulator_add: width-extended add with carry-out and optional clamp to all-ones
module accumulator_add
  import accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int SUM_W = SUM_W_DFLT,
  parameter bit SATURATE = WRAP
) (
  input  logic [SUM_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  y,
  output logic              carry
);
  logic [SUM_W:0] s;
  always_comb begin
    s = {1'b0, a} + (SUM_W+1)'(b);
    carry = s[SUM_W];
    y = (SATURATE && carry) ? '1 : s[SUM_W-1:0];
  end
endmodule

// File: rtl/accumulator.sv
// accumulator: registered running sum with sticky overflow, wrap or saturate
module accumulator
  import accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int SUM_W = SUM_W_DFLT,
  parameter bit SATURATE = WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [SUM_W-1:0]  sum,
  output logic              overflow
);
  logic [SUM_W-1:0] nxt;
  logic carry;
  accumulator_add #(.DATA_W(DATA_W), .SUM_W(SUM_W), .SATURATE(SATURATE)) u_add (
    .a(sum), .b(data_in), .y(nxt), .carry(carry)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      sum <= '0;
      overflow <= 1'b0;
    end else begin
      sum <= nxt;
      overflow <= overflow | carry;
    end
endmodule

// File: tb/tb_accumulator.sv
// tb_accumulator: directed checks of wrap and saturate accumulator instances
module tb_accumulator;
  import accumulator_pkg::*;
  logic clk = 1'b0;
  int pass = 0;
  int total = 0;
  always #4 clk = ~clk;
  accumulator_if #(.DATA_W(8), .SUM_W(16)) a ();
  accumulator_if #(.DATA_W(8), .SUM_W(16)) s ();
  accumulator #(.DATA_W(8), .SUM_W(16), .SATURATE(WRAP)) dut_w (
    .clk(clk), .rst(a.rst), .data_in(a.data_in), .sum(a.sum), .overflow(a.overflow)
  );
  accumulator #(.DATA_W(8), .SUM_W(16), .SATURATE(SAT)) dut_s (
    .clk(clk), .rst(s.rst), .data_in(s.data_in), .sum(s.sum), .overflow(s.overflow)
  );

  task automatic step(input logic [7:0] d, input logic r);
    @(negedge clk);
    a.data_in = d; s.data_in = d;
    a.rst = r; s.rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(8'h55, 1'b0);
    step(8'h55, 1'b0);
    total++; if (a.sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", a.sum); else pass++;
    total++; if (a.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", a.overflow); else pass++;
  endtask

  task automatic test_accumulate();
    logic [15:0] exp [4] = '{16'd1, 16'd3, 16'd6, 16'd10};
    for (int i = 0; i < 4; i++) begin
      step(8'(i + 1), 1'b1);
      total++; if (a.sum !== exp[i]) $display("FAIL accum_%0d got %0d want %0d", i, a.sum, exp[i]); else pass++;
    end
    total++; if (a.overflow !== 1'b0) $display("FAIL accum_ovf got %b want 0", a.overflow); else pass++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b1);
      total++; if (a.sum !== 16'd10) $display("FAIL hold_%0d got %0d want 10", i, a.sum); else pass++;
    end
  endtask

  task automatic test_async_glitch();
    step(8'h00, 1'b0);
    step(8'h05, 1'b1);
    @(negedge clk);
    a.data_in = 8'h00; s.data_in = 8'h00;
    #1 a.rst = 1'b0; s.rst = 1'b0;
    #1 a.rst = 1'b1; s.rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (a.sum !== 16'd5) $display("FAIL glitch_sum got %0d want 5", a.sum); else pass++;
  endtask

  task automatic test_reset_mid();
    step(8'h00, 1'b0);
    step(8'd100, 1'b1);
    total++; if (a.sum !== 16'd100) $display("FAIL mid_pre got %0d want 100", a.sum); else pass++;
    step(8'd7, 1'b0);
    total++; if (a.sum !== 16'd0) $display("FAIL mid_rst_sum got %0d want 0", a.sum); else pass++;
    total++; if (a.overflow !== 1'b0) $display("FAIL mid_rst_ovf got %b want 0", a.overflow); else pass++;
    step(8'd7, 1'b1);
    total++; if (a.sum !== 16'd7) $display("FAIL mid_post got %0d want 7", a.sum); else pass++;
  endtask

  task automatic test_wrap();
    step(8'h00, 1'b0);
    for (int i = 0; i < 257; i++) step(8'hFF, 1'b1);
    total++; if (a.sum !== 16'hFFFF) $display("FAIL wrap_max got %h want ffff", a.sum); else pass++;
    total++; if (a.overflow !== 1'b0) $display("FAIL wrap_exact_ovf got %b want 0", a.overflow); else pass++;
    step(8'hFF, 1'b1);
    total++; if (a.sum !== 16'h00FE) $display("FAIL wrap_sum got %h want 00fe", a.sum); else pass++;
    total++; if (a.overflow !== 1'b1) $display("FAIL wrap_ovf got %b want 1", a.overflow); else pass++;
    step(8'h01, 1'b1);
    total++; if (a.sum !== 16'h00FF) $display("FAIL wrap_after got %h want 00ff", a.sum); else pass++;
    total++; if (a.overflow !== 1'b1) $display("FAIL wrap_sticky got %b want 1", a.overflow); else pass++;
    step(8'h00, 1'b0);
    total++; if (a.overflow !== 1'b0) $display("FAIL wrap_ovf_clr got %b want 0", a.overflow); else pass++;
  endtask

  task automatic test_saturate();
    step(8'h00, 1'b0);
    for (int i = 0; i < 257; i++) step(8'hFF, 1'b1);
    total++; if (s.sum !== 16'hFFFF) $display("FAIL sat_max got %h want ffff", s.sum); else pass++;
    total++; if (s.overflow !== 1'b0) $display("FAIL sat_exact_ovf got %b want 0", s.overflow); else pass++;
    step(8'hFF, 1'b1);
    total++; if (s.sum !== 16'hFFFF) $display("FAIL sat_clamp got %h want ffff", s.sum); else pass++;
    total++; if (s.overflow !== 1'b1) $display("FAIL sat_ovf got %b want 1", s.overflow); else pass++;
    for (int i = 0; i < 3; i++) begin
      step(8'h80, 1'b1);
      total++; if (s.sum !== 16'hFFFF) $display("FAIL sat_stay_%0d got %h want ffff", i, s.sum); else pass++;
    end
    step(8'h00, 1'b1);
    total++; if (s.sum !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", s.sum); else pass++;
    total++; if (s.overflow !== 1'b1) $display("FAIL sat_sticky got %b want 1", s.overflow); else pass++;
  endtask

  initial begin
    a.rst = 1'b0; s.rst = 1'b0;
    a.data_in = 8'h00; s.data_in = 8'h00;
    test_reset();
    test_accumulate();
    test_hold();
    test_async_glitch();
    test_reset_mid();
    test_wrap();
    test_saturate();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
